// File: rtl/histo_engine.sv
// Ping-pong pixel histogram: bins valid pixels into the accumulation bank and
// serves bus reads from the frozen bank; banks swap and the new one is cleared per frame.
module histo_engine #(
   parameter int PIXEL_WIDTH = 12,
   parameter int BIN_BITS    = 8,
   parameter int COUNT_WIDTH = 32,
   parameter int DROP_WIDTH  = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   pix_valid,
   input  logic [PIXEL_WIDTH-1:0] pix_data,
   input  logic                   frame_start,
   input  logic [BIN_BITS-1:0]    hm_address,
   input  logic                   hm_bus_enable,
   input  logic                   hm_rw,
   output logic                   hm_acknowledge,
   output logic [COUNT_WIDTH-1:0] hm_read_data,
   output logic                   irq,
   input  logic                   irq_clear,
   output logic                   overrun,
   output logic                   busy,
   output logic [15:0]            frame_count,
   output logic [DROP_WIDTH-1:0]  drop_count
);

   localparam int NBINS = 1 << BIN_BITS;

   typedef enum logic {S_CLEAR, S_RUN} state_t;

   function automatic logic [COUNT_WIDTH-1:0] sat_inc_count(input logic [COUNT_WIDTH-1:0] v);
      return (&v) ? v : v + COUNT_WIDTH'(1);
   endfunction

   function automatic logic [DROP_WIDTH-1:0] sat_inc_drop(input logic [DROP_WIDTH-1:0] v);
      return (&v) ? v : v + DROP_WIDTH'(1);
   endfunction

   state_t                state_q;
   logic                  wr_bank_q;
   logic                  clr_both_q;
   logic [BIN_BITS-1:0]   clr_addr_q;
   logic                  irq_q;
   logic                  overrun_q;
   logic [15:0]           frame_count_q;
   logic [DROP_WIDTH-1:0] drop_q;
   logic                  ack_q;
   logic [COUNT_WIDTH-1:0] rdata_q;

   logic [COUNT_WIDTH-1:0] mem_q [2*NBINS];

   logic                   vld_p0, vld_p1, vld_p2;
   logic [BIN_BITS-1:0]    bin_p0, bin_p1, bin_p2;
   logic                   bank_p0, bank_p1, bank_p2;
   logic [COUNT_WIDTH-1:0] ram_p0, cnt_p1, cnt_p2;

   logic [COUNT_WIDTH-1:0] fwd_cnt;
   logic [COUNT_WIDTH-1:0] cnt_d;
   logic [COUNT_WIDTH-1:0] bus_val;
   logic [BIN_BITS-1:0]    pix_bin;
   logic                   pix_acc;
   logic                   swap;
   logic                   bus_req;
   logic                   rd_bank;
   logic                   unused_pix;

   assign pix_bin    = pix_data[PIXEL_WIDTH-1 -: BIN_BITS];
   assign unused_pix = ^pix_data;
   assign pix_acc    = pix_valid && (state_q == S_RUN);
   assign swap       = frame_start && (state_q == S_RUN);
   assign bus_req    = hm_bus_enable && !ack_q;
   assign rd_bank    = ~wr_bank_q;

   // S1: newest in-flight value for this bin wins over the RAM read
   always_comb begin
      fwd_cnt = ram_p0;
      if (vld_p2 && bin_p2 == bin_p0 && bank_p2 == bank_p0) fwd_cnt = cnt_p2;
      if (vld_p1 && bin_p1 == bin_p0 && bank_p1 == bank_p0) fwd_cnt = cnt_p1;
      cnt_d = sat_inc_count(fwd_cnt);
   end

   // A read colliding with this cycle's S2 write must see the new count
   always_comb begin
      bus_val = mem_q[{rd_bank, hm_address}];
      if (vld_p1 && bank_p1 == rd_bank && bin_p1 == hm_address) bus_val = cnt_p1;
   end

   always_ff @(posedge clk) begin
      ram_p0 <= mem_q[{wr_bank_q, pix_bin}];
      if (vld_p1) mem_q[{bank_p1, bin_p1}] <= cnt_p1;
      if (state_q == S_CLEAR) begin
         mem_q[{wr_bank_q, clr_addr_q}] <= '0;
         if (clr_both_q) mem_q[{~wr_bank_q, clr_addr_q}] <= '0;
      end
   end

   // S0 -> S1 -> S2 datapath
   always_ff @(posedge clk) begin
      bin_p0  <= pix_bin;
      bank_p0 <= wr_bank_q;
      bin_p1  <= bin_p0;
      bank_p1 <= bank_p0;
      cnt_p1  <= cnt_d;
      bin_p2  <= bin_p1;
      bank_p2 <= bank_p1;
      cnt_p2  <= cnt_p1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else begin
         vld_p0 <= pix_acc;
         vld_p1 <= vld_p0;
         vld_p2 <= vld_p1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_CLEAR;
         wr_bank_q     <= 1'b0;
         clr_both_q    <= 1'b1;
         clr_addr_q    <= '0;
         irq_q         <= 1'b0;
         overrun_q     <= 1'b0;
         frame_count_q <= '0;
         drop_q        <= '0;
         ack_q         <= 1'b0;
         rdata_q       <= '0;
      end else begin
         ack_q <= bus_req;
         if (bus_req && hm_rw) rdata_q <= bus_val;

         if (swap) irq_q <= 1'b1;
         else if (irq_clear) irq_q <= 1'b0;

         case (state_q)
            S_CLEAR: begin
               if (frame_start) overrun_q <= 1'b1;
               if (pix_valid) drop_q <= sat_inc_drop(drop_q);
               clr_addr_q <= clr_addr_q + BIN_BITS'(1);
               if (&clr_addr_q) begin
                  state_q    <= S_RUN;
                  clr_both_q <= 1'b0;
               end
            end
            S_RUN: begin
               if (frame_start) begin
                  wr_bank_q     <= ~wr_bank_q;
                  frame_count_q <= frame_count_q + 16'd1;
                  clr_addr_q    <= '0;
                  state_q       <= S_CLEAR;
               end
            end
            default: state_q <= S_CLEAR;
         endcase
      end
   end

   assign hm_acknowledge = ack_q;
   assign hm_read_data   = rdata_q;
   assign irq            = irq_q;
   assign overrun        = overrun_q;
   assign busy           = (state_q == S_CLEAR);
   assign frame_count    = frame_count_q;
   assign drop_count     = drop_q;

endmodule
